// File: rtl/axi_sram_subsystem.sv
// axi_sram_subsystem: idle AXI master stub feeding a single-beat AXI slave bridge in front of a 64-bit synchronous SRAM.
// Traffic is injected by forcing the stub's nets; the stub itself only ever drives zeros.
module fake_cpu (
    input  logic        clk,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [63:0] wdata,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [63:0] rdata,
    input  logic        rvalid,
    output logic        rready
);
    always_ff @(posedge clk) begin
        awaddr  <= '0;
        awvalid <= 1'b0;
        wdata   <= '0;
        wlast   <= 1'b0;
        wvalid  <= 1'b0;
        bready  <= 1'b0;
        araddr  <= '0;
        arvalid <= 1'b0;
        rready  <= 1'b0;
    end

    logic unused_ok;
    assign unused_ok = ^{awready, wready, bvalid, arready, rdata, rvalid};
endmodule

module axi_sram_subsystem #(
    parameter int ADDR_W = 10
) (
    input logic clk,
    input logic resetn
);
    typedef enum logic [2:0] {IDLE, WRITE, BRESP, READ, RCAP, RRESP} state_t;

    logic [31:0] awaddr, araddr;
    logic [63:0] wdata, rdata;
    logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rvalid, rready;

    fake_cpu fake_cpu (.*);

    state_t state, next;
    logic en, aw_got, w_got, aw_hs, w_hs, ar_hs;
    logic [ADDR_W-1:0] aw_idx, ar_idx, sram_addr;
    logic [63:0] w_q, mem_q;
    logic [63:0] mem [2**ADDR_W];

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign ar_hs = arvalid && arready;

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = ((aw_got || aw_hs) && (w_got || w_hs)) ? WRITE : ar_hs ? READ : IDLE;
            WRITE:   next = BRESP;
            BRESP:   next = bready ? IDLE : BRESP;
            READ:    next = RCAP;
            RCAP:    next = RRESP;
            RRESP:   next = rready ? IDLE : RRESP;
            default: next = IDLE;
        endcase
    end

    // Reads are held off while any write half is pending so writes win.
    always_comb begin
        awready = en && state == IDLE && !aw_got;
        wready  = en && state == IDLE && !w_got;
        arready = en && state == IDLE && !(awvalid || wvalid || aw_got || w_got);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            en     <= 1'b0;
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            bvalid <= 1'b0;
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            en <= 1'b1;
            if (aw_hs) begin
                aw_got <= 1'b1;
                aw_idx <= awaddr[ADDR_W+2:3];
            end
            if (w_hs) begin
                w_got <= 1'b1;
                w_q   <= wdata;
            end
            if (ar_hs) ar_idx <= araddr[ADDR_W+2:3];
            if (state == WRITE) begin
                bvalid <= 1'b1;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
            if (state == BRESP && bready) bvalid <= 1'b0;
            if (state == RCAP) begin
                rvalid <= 1'b1;
                rdata  <= mem_q;
            end
            if (state == RRESP && rready) rvalid <= 1'b0;
        end
    end

    assign sram_addr = (state == WRITE) ? aw_idx : ar_idx;

    always_ff @(posedge clk) begin
        if (state == WRITE) mem[sram_addr] <= w_q;
        mem_q <= mem[sram_addr];
    end

    logic unused_ok;
    assign unused_ok = ^{wlast, awaddr[31:ADDR_W+3], awaddr[2:0], araddr[31:ADDR_W+3], araddr[2:0]};
endmodule

// File: tb/tb_axi_sram_subsystem.sv
// tb_axi_sram_subsystem: directed AXI traffic forced onto the stub, checked against a word-array memory model.
module tb_axi_sram_subsystem;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    axi_sram_subsystem #(.ADDR_W(AW)) dut (.clk(clk), .resetn(resetn));

    logic [31:0] t_awaddr = '0, t_araddr = '0;
    logic [63:0] t_wdata = '0;
    logic t_awvalid = 1'b0, t_wvalid = 1'b0, t_wlast = 1'b0, t_bready = 1'b0;
    logic t_arvalid = 1'b0, t_rready = 1'b0;

    always @* begin
        force dut.fake_cpu.awaddr  = t_awaddr;
        force dut.fake_cpu.awvalid = t_awvalid;
        force dut.fake_cpu.wdata   = t_wdata;
        force dut.fake_cpu.wlast   = t_wlast;
        force dut.fake_cpu.wvalid  = t_wvalid;
        force dut.fake_cpu.bready  = t_bready;
        force dut.fake_cpu.araddr  = t_araddr;
        force dut.fake_cpu.arvalid = t_arvalid;
        force dut.fake_cpu.rready  = t_rready;
    end

    int tests = 0, fails = 0;
    logic [63:0] mem_m [int];
    logic [63:0] exp_q [$];
    logic prev_rhold = 1'b0, prev_bhold = 1'b0;
    logic [63:0] prev_rdata = '0;

    function automatic int midx(input logic [31:0] a);
        return int'(a / 8) % (1 << AW);
    endfunction

    task automatic check(input logic [63:0] act, input logic [63:0] exp, input string name);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle protocol and data checks against the model.
    always @(negedge clk) begin
        if (!resetn) begin
            prev_rhold = 1'b0;
            prev_bhold = 1'b0;
        end else begin
            if (prev_rhold) begin
                check(64'(dut.fake_cpu.rvalid), 64'd1, "rvalid_hold");
                check(dut.fake_cpu.rdata, prev_rdata, "rdata_stable");
            end
            if (prev_bhold) check(64'(dut.fake_cpu.bvalid), 64'd1, "bvalid_hold");
            if (dut.fake_cpu.bvalid || dut.fake_cpu.rvalid)
                check(64'({dut.fake_cpu.awready, dut.fake_cpu.wready, dut.fake_cpu.arready}), 64'd0, "ready_busy");
            if (dut.fake_cpu.rvalid && t_rready) begin
                if (exp_q.size() == 0) check(64'(dut.fake_cpu.rvalid), 64'd0, "r_unexpected");
                else check(dut.fake_cpu.rdata, exp_q.pop_front(), "rdata_model");
            end
            prev_rhold = dut.fake_cpu.rvalid && !t_rready;
            prev_bhold = dut.fake_cpu.bvalid && !t_bready;
            prev_rdata = dut.fake_cpu.rdata;
        end
    end

    task automatic write_txn(input logic [31:0] a, input logic [63:0] d, input bit w_first, input int bdly);
        bit aw_sent = 0, aw_pend = 0, w_pend = 1, done = 0, hs_aw, hs_w;
        t_wdata = d; t_wvalid = 1'b1; t_wlast = 1'b1;
        for (int cyc = 0; cyc < 50 && !done; cyc++) begin
            if (!aw_sent && cyc >= (w_first ? 3 : 0)) begin
                t_awaddr = a; t_awvalid = 1'b1; aw_sent = 1; aw_pend = 1;
            end
            @(negedge clk);
            if (t_arvalid && (t_awvalid || t_wvalid)) check(64'(dut.fake_cpu.arready), 64'd0, "ar_blocked");
            if (!w_pend && aw_pend) check(64'(dut.fake_cpu.wready), 64'd0, "wready_drop");
            hs_aw = t_awvalid && dut.fake_cpu.awready;
            hs_w  = t_wvalid && dut.fake_cpu.wready;
            @(posedge clk); #1;
            if (hs_aw) begin t_awvalid = 1'b0; aw_pend = 0; end
            if (hs_w)  begin t_wvalid = 1'b0; t_wlast = 1'b0; w_pend = 0; end
            done = aw_sent && !aw_pend && !w_pend;
        end
        check(64'(done), 64'd1, "aw_w_handshake");
        mem_m[midx(a)] = d;
        @(negedge clk) check(64'(dut.fake_cpu.bvalid), 64'd0, "b_not_yet");
        @(posedge clk); #1;
        for (int k = 0; k < bdly; k++) begin
            @(negedge clk) check(64'(dut.fake_cpu.bvalid), 64'd1, "b_wait");
            @(posedge clk); #1;
        end
        t_bready = 1'b1;
        @(negedge clk) check(64'(dut.fake_cpu.bvalid), 64'd1, "b_valid");
        @(posedge clk); #1;
        t_bready = 1'b0;
        if (!t_arvalid) begin
            @(negedge clk);
            check(64'(dut.fake_cpu.bvalid), 64'd0, "b_drop");
            check(64'({dut.fake_cpu.awready, dut.fake_cpu.arready}), 64'd3, "idle_after_b");
            @(posedge clk); #1;
        end
    endtask

    task automatic read_txn(input logic [31:0] a, input logic [63:0] lit, input int rr_delay);
        bit done = 0, hs;
        check(mem_m[midx(a)], lit, "model_pin");
        exp_q.push_back(mem_m[midx(a)]);
        t_araddr = a; t_arvalid = 1'b1; t_rready = (rr_delay == 0);
        for (int cyc = 0; cyc < 50 && !done; cyc++) begin
            @(negedge clk) hs = dut.fake_cpu.arready;
            @(posedge clk); #1;
            if (hs) begin t_arvalid = 1'b0; done = 1; end
        end
        check(64'(done), 64'd1, "ar_handshake");
        @(negedge clk) check(64'(dut.fake_cpu.rvalid), 64'd0, "r_lat1");
        @(posedge clk); #1;
        @(negedge clk) check(64'(dut.fake_cpu.rvalid), 64'd0, "r_lat2");
        @(posedge clk); #1;
        @(negedge clk);
        check(64'(dut.fake_cpu.rvalid), 64'd1, "r_valid");
        check(dut.fake_cpu.rdata, lit, "r_data");
        if (rr_delay > 0) begin
            t_araddr = 32'h18; t_arvalid = 1'b1;
            for (int k = 0; k < rr_delay; k++) begin
                @(posedge clk); #1;
                if (k == rr_delay - 1) begin t_arvalid = 1'b0; t_rready = 1'b1; end
                @(negedge clk);
                check(64'(dut.fake_cpu.arready), 64'd0, "ar_busy");
                check(dut.fake_cpu.rdata, lit, "r_held");
            end
        end
        @(posedge clk); #1;
        t_rready = 1'b0;
        @(negedge clk);
        check(64'(dut.fake_cpu.rvalid), 64'd0, "r_drop");
        check(64'(dut.fake_cpu.arready), 64'd1, "ar_idle");
        @(posedge clk); #1;
    endtask

    initial begin
        bit up = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check(64'({dut.fake_cpu.awready, dut.fake_cpu.wready, dut.fake_cpu.arready,
                       dut.fake_cpu.bvalid, dut.fake_cpu.rvalid}), 64'd0, "reset_ctrl");
            check(dut.fake_cpu.rdata, 64'd0, "reset_rdata");
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        for (int k = 0; k < 2 && !up; k++) begin
            @(negedge clk) up = dut.fake_cpu.awready && dut.fake_cpu.wready && dut.fake_cpu.arready;
            @(posedge clk); #1;
        end
        check(64'(up), 64'd1, "ready_after_reset");

        write_txn(32'h4, 64'habcdaaaa12345678, 0, 5);
        read_txn(32'h4, 64'habcdaaaa12345678, 0);

        write_txn(32'h10, 64'h1111, 1, 0);
        read_txn(32'h10, 64'h1111, 0);

        t_araddr = 32'h4; t_arvalid = 1'b1; t_rready = 1'b1;
        write_txn(32'h8, 64'h22, 0, 1);
        read_txn(32'h4, 64'habcdaaaa12345678, 0);
        read_txn(32'h8, 64'h22, 0);

        write_txn(32'h0, 64'ha5, 0, 0);
        write_txn(32'h4, 64'h5a, 0, 2);
        read_txn(32'h0, 64'h5a, 0);

        read_txn(32'h10, 64'h1111, 4);

        check(64'(exp_q.size()), 64'd0, "all_reads_seen");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
